edge_rom_arb: RTL
=================

# edge_rom_arb

Round-robin arbiter and read sequencer that shares the single edge-mask ROM (11-bit {x,y,z} address, 4096-bit word, registered BRAM output) between several parameter-check requesters. It sits between the requesters and the ROM instance: it grants one request per cycle, drives the ROM address, and routes a per-requester valid strobe alongside the broadcast ROM data word when the read completes. Fully pipelined: one read issued per cycle, responses return in issue order.

## Interface
- NREQ, 4: number of requesters (2..8).
- ADDR_W, 11: ROM address width ({x[2:0], y[3:0], z[3:0]}).
- DATA_W, 4096: ROM word width (edge mask).
- RD_LAT, 1: ROM read latency in cycles from sampled address to valid douta (>=1).

- CLK  in  1  single clock; all state on rising edge.
- RST_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  request per requester; held with addr until granted.
- lock  in  NREQ  requester i keeps priority while req[i] and lock[i] both high.
- addr  in  NREQ*ADDR_W  packed request addresses; requester i at [i*ADDR_W +: ADDR_W].
- gnt  out  NREQ  one-hot/zero, combinational; request and addr accepted in this cycle.
- rom_addr  out  ADDR_W  registered ROM address (to addra).
- rom_dout  in  DATA_W  ROM data (from douta).
- rsp_valid  out  NREQ  one-hot/zero, registered; rsp_data is the read for requester i.
- rsp_data  out  DATA_W  combinational pass-through of rom_dout.
- idle  out  1  high when no req is asserted and no read is in flight.

## Operation
- Priority pointer ptr (0..NREQ-1), reset 0. Winner = first i with req[i]=1 scanning ptr, ptr+1, ... mod NREQ.
- gnt[winner]=1 same cycle; gnt all-zero when req all-zero.
- Pointer update on grant to i: if lock[i]=1, ptr stays i; else ptr = (i+1) mod NREQ. No grant: ptr unchanged.
- lock[j] for a requester not currently granted has no effect.
- On grant: rom_addr <= addr[winner]; tag pipeline stage 0 <= one-hot(winner). No grant: rom_addr holds, stage 0 <= 0.
- Tag pipeline: RD_LAT+1 stages of NREQ bits, shifted every cycle; last stage drives rsp_valid.
- rsp_data not registered (avoids a 4096-bit flop bank); consumers sample it only when their rsp_valid bit is high.
- idle = (req == 0) && (all tag stages == 0).
- Requester deasserting req before grant: request dropped, no response. addr changes while req high and not granted: the value present in the grant cycle is used.

## Timing
- Reset (async, immediate): ptr=0, rom_addr=0, all tag stages=0, so rsp_valid=0 and idle=1 (gnt follows req combinationally). In-flight reads are discarded; no rsp_valid after reset release for pre-reset grants.
- Grant in cycle t -> rom_addr valid cycle t+1 -> ROM samples at end of t+1 -> rsp_valid in cycle t+1+RD_LAT (t+2 for RD_LAT=1).
- Throughput: one grant per cycle sustained; back-to-back grants yield back-to-back rsp_valid with no bubbles.
- Responses strictly in grant order; at most one rsp_valid bit high per cycle.
- Single requester continuously requesting is granted every cycle regardless of lock.

## Test plan
- Reset release, req=0001, addr[0]=0x123, RD_LAT=1 -> gnt=0001 in cycle t, rom_addr=0x123 at t+1, rsp_valid=0001 at t+2 with rsp_data = ROM[0x123]; idle=1 at t+3.
- req=1111 held, lock=0, ptr=0 -> gnt sequence 0001,0010,0100,1000,0001; rsp_valid same sequence delayed 2 cycles; each rsp_data matches that requester's address.
- After grant to requester 2, req=1001 -> gnt=1000 (requester 3), then gnt=0001.
- req=0011, lock=0001 from ptr=0 -> gnt=0001 every cycle while lock[0] high; drop lock[0] -> next cycle gnt=0010.
- Grant at t, assert RST_n=0 at t+1 for one cycle -> rsp_valid stays 0 through t+4, rom_addr=0, ptr=0, idle=1 during reset.
- RD_LAT=3 build, grants at t and t+1 -> rsp_valid at t+4 and t+5, in order; idle goes high at t+6 with req=0.

Source files
------------

// File: rtl/edge_rom_arb.sv
// Round-robin arbiter and read sequencer that shares one registered-output edge-mask ROM
// between NREQ requesters; responses return in grant order with a per-requester valid strobe.
module edge_rom_arb #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 4096,
    parameter int RD_LAT = 1
) (
    input  logic                     CLK,
    input  logic                     RST_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          lock,
    input  logic [NREQ*ADDR_W-1:0]   addr,
    output logic [NREQ-1:0]          gnt,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [DATA_W-1:0]        rom_dout,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     idle
);

    localparam int PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nxt;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] cand;
    logic             found;
    int               idx;

    // One grant tag per ROM pipeline stage; the last stage lines up with valid douta.
    logic [NREQ-1:0]  tag [RD_LAT+1];
    logic             busy;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        found   = 1'b0;
        win     = '0;
        cand    = '0;
        idx     = 0;
        gnt     = '0;
        ptr_nxt = ptr;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = PTR_W'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        if (found) begin
            gnt[win] = 1'b1;
            // A locked winner keeps priority; otherwise rotate just past it.
            if (lock[win]) ptr_nxt = win;
            else           ptr_nxt = PTR_W'((int'(win) + 1) % NREQ);
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            ptr      <= '0;
            rom_addr <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            ptr <= ptr_nxt;
            if (found) rom_addr <= addr[int'(win)*ADDR_W +: ADDR_W];
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            // NOTE: the tag pipeline is reset so reads in flight at reset never surface.
            for (int i = 0; i <= RD_LAT; i++) tag[i] <= '0;
        end else begin
            tag[0] <= gnt;
            for (int i = 1; i <= RD_LAT; i++) tag[i] <= tag[i-1];
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i <= RD_LAT; i++) busy = busy | (|tag[i]);
    end

    assign rsp_valid = tag[RD_LAT];
    assign rsp_data  = rom_dout;
    assign idle      = (req == '0) && !busy;

endmodule
